// File: rtl/mem_pkg.sv
// Shared encodings for the byte-strobed memory: collision policy codes and clear FSM states.
package mem_pkg;

    // Same-address read/write policy selected by the COLLISION parameter.
    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Clear FSM: CLEAR zero-fills the array after reset, RUN serves requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit byte lane: 2^DEPTH-deep array, one write port, one registered read port.
module byte_lane_ram #(
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [7:0]       rdata
);

    localparam int WORDS = 1 << DEPTH;

    logic [7:0] mem_q [WORDS];
    logic [7:0] rdata_q, rdata_d;

    // Storage write port.
    // NOTE: the array has no reset branch; resetting memories turns RAM into flops, so zero-fill is done by the clear FSM instead.
    always_ff @(posedge CLK) begin
        if (we) begin
            // NOTE: non-blocking here makes a same-edge read see the old word, which is what read-first relies on.
            mem_q[waddr] <= wdata;
        end
    end

    // Read data register loads only on a read and otherwise holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read data register; reset so DOUT is zero while RST is high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/byte_strb_mem.sv
// Byte-strobed dual-port memory with post-reset clear, collision policy and 1- or 2-cycle read latency.
module byte_strb_mem
    import mem_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int RD_LAT       = 1,
    parameter int COLLISION    = READ_FIRST,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WEN,
    input  logic [WIDTH/8-1:0] WSTRB,
    input  logic [DEPTH-1:0]   WADDR,
    input  logic [WIDTH-1:0]   DIN,
    input  logic               REN,
    input  logic [DEPTH-1:0]   RADDR,
    output logic [WIDTH-1:0]   DOUT,
    output logic               DVALID,
    output logic               BUSY
);

    localparam int               LANES     = WIDTH / 8;
    localparam logic [DEPTH-1:0] LAST_ADDR = '1;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   cnt_q, cnt_d;
    logic               busy;
    logic               wr_ok, rd_ok;

    logic [LANES-1:0]   lane_we;
    logic [DEPTH-1:0]   lane_waddr;
    logic [WIDTH-1:0]   lane_wdata;
    logic [WIDTH-1:0]   lane_rdata;

    logic [LANES-1:0]   hit_q, hit_d;
    logic [WIDTH-1:0]   fwd_q, fwd_d;
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   rd_word;

    assign busy  = (state_q == ST_CLEAR);
    assign BUSY  = busy;
    assign wr_ok = WEN & ~busy;
    assign rd_ok = REN & ~busy;

    // Clear FSM next state: walk cnt across every address, then serve requests.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Clear FSM state register; reset restarts the clear from address 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane write steering: the clear owns the write port while busy.
    always_comb begin
        lane_waddr = busy ? cnt_q : WADDR;
        lane_wdata = busy ? '0 : DIN;
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = busy | (wr_ok & WSTRB[i]);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        byte_lane_ram #(
            .DEPTH (DEPTH)
        ) u_lane (
            .CLK   (CLK),
            .RST   (RST),
            .we    (lane_we[i]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[i*8 +: 8]),
            .re    (rd_ok),
            .raddr (RADDR),
            .rdata (lane_rdata[i*8 +: 8])
        );
    end

    // Capture which lanes collide with an accepted read and the data to forward.
    always_comb begin
        hit_d = hit_q;
        fwd_d = fwd_q;
        v1_d  = rd_ok;
        if (rd_ok) begin
            hit_d = (wr_ok && (WADDR == RADDR)) ? WSTRB : '0;
            fwd_d = DIN;
        end
    end

    // First read stage: valid flag plus collision bookkeeping aligned with lane read data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_q <= '0;
            fwd_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            hit_q <= hit_d;
            fwd_q <= fwd_d;
            v1_q  <= v1_d;
        end
    end

    // Collision merge: in write-first mode strobed lanes take the forwarded write data.
    always_comb begin
        rd_word = lane_rdata;
        if (COLLISION == WRITE_FIRST) begin
            for (int i = 0; i < LANES; i++) begin
                if (hit_q[i]) begin
                    rd_word[i*8 +: 8] = fwd_q[i*8 +: 8];
                end
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [WIDTH-1:0] dout2_q, dout2_d;
        logic             dv2_q, dv2_d;

        // Second stage loads on every completed first stage, so back-to-back reads never drop.
        always_comb begin
            dout2_d = v1_q ? rd_word : dout2_q;
            dv2_d   = v1_q;
        end

        // Second stage register; reset kills any read still in flight.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                dout2_q <= '0;
                dv2_q   <= 1'b0;
            end else begin
                dout2_q <= dout2_d;
                dv2_q   <= dv2_d;
            end
        end

        assign DOUT   = dout2_q;
        assign DVALID = dv2_q;
    end else begin : g_lat1
        assign DOUT   = rd_word;
        assign DVALID = v1_q;
    end

endmodule

// File: tb/tb_byte_strb_mem.sv
// Scoreboard bench: two instances (RD_LAT=1/read-first and RD_LAT=2/write-first) share stimulus.
module tb_byte_strb_mem;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WEN = 1'b0;
    logic [3:0]  WSTRB = '0;
    logic [3:0]  WADDR = '0;
    logic [31:0] DIN = '0;
    logic        REN = 1'b0;
    logic [3:0]  RADDR = '0;

    logic [31:0] dout_a, dout_b;
    logic        dvalid_a, dvalid_b, busy_a, busy_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    byte_strb_mem #(.WIDTH(32), .DEPTH(4), .RD_LAT(1), .COLLISION(READ_FIRST),
                    .CLEAR_ON_RST(1)) dut_a (
        .CLK(CLK), .RST(RST), .WEN(WEN), .WSTRB(WSTRB), .WADDR(WADDR), .DIN(DIN),
        .REN(REN), .RADDR(RADDR), .DOUT(dout_a), .DVALID(dvalid_a), .BUSY(busy_a)
    );

    byte_strb_mem #(.WIDTH(32), .DEPTH(4), .RD_LAT(2), .COLLISION(WRITE_FIRST),
                    .CLEAR_ON_RST(1)) dut_b (
        .CLK(CLK), .RST(RST), .WEN(WEN), .WSTRB(WSTRB), .WADDR(WADDR), .DIN(DIN),
        .REN(REN), .RADDR(RADDR), .DOUT(dout_b), .DVALID(dvalid_b), .BUSY(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One edge of stimulus; an accepted read pushes its expected word and due cycle per instance.
    task automatic op(input logic wen, input logic [3:0] strb, input logic [3:0] waddr,
                      input logic [31:0] din, input logic ren, input logic [3:0] raddr,
                      input logic [31:0] exp_a, input logic [31:0] exp_b);
        @(negedge CLK);
        WEN = wen; WSTRB = strb; WADDR = waddr; DIN = din;
        REN = ren; RADDR = raddr;
        if (ren) begin
            qa.push_back('{data: exp_a, due: cyc + 1});
            qb.push_back('{data: exp_b, due: cyc + 2});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Counts cycles from the current negedge until BUSY falls on both instances.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check(name, n, 16);
    endtask

    // Monitor for instance A (RD_LAT=1, read-first).
    always @(negedge CLK) begin
        exp_t e;
        if (qa.size() != 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            check("a_dvalid", {31'b0, dvalid_a}, 32'h1);
            check("a_dout", dout_a, e.data);
        end else if (dvalid_a) begin
            check("a_spurious_dvalid", 32'h1, 32'h0);
        end
    end

    // Monitor for instance B (RD_LAT=2, write-first).
    always @(negedge CLK) begin
        exp_t e;
        if (qb.size() != 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            check("b_dvalid", {31'b0, dvalid_b}, 32'h1);
            check("b_dout", dout_b, e.data);
        end else if (dvalid_b) begin
            check("b_spurious_dvalid", 32'h1, 32'h0);
        end
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_dout_a", dout_a, 32'h0);
        check("rst_dout_b", dout_b, 32'h0);
        check("rst_dvalid", {30'b0, dvalid_a, dvalid_b}, 32'h0);
        check("rst_busy", {30'b0, busy_a, busy_b}, 32'h3);

        // Release reset with requests held during the clear: addr 0 is cleared first,
        // so any leaked write of all-ones would survive; leaked reads show as spurious DVALID.
        RST = 1'b0;
        WEN = 1'b1; WSTRB = 4'hF; WADDR = 4'h0; DIN = 32'hFFFF_FFFF;
        REN = 1'b1; RADDR = 4'h0;
        count_busy("busy_len_initial");
        WEN = 1'b0; REN = 1'b0;

        // All addresses read back zero, back to back.
        for (int a = 0; a < 16; a++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 32'h0, 32'h0);
        idle(3);

        // Strobed writes to addr 3, then a zero-strobe write that must not change it.
        op(1'b1, 4'hF, 4'h3, 32'hAABB_CCDD, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b1, 4'h5, 4'h3, 32'h1122_3344, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3, 32'hAA22_CC44, 32'hAA22_CC44);
        op(1'b1, 4'h0, 4'h3, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3, 32'hAA22_CC44, 32'hAA22_CC44);

        // Full-word collision on addr 5, then confirm the write landed.
        op(1'b1, 4'hF, 4'h5, 32'hDEAD_BEEF, 1'b1, 4'h5, 32'h0, 32'hDEAD_BEEF);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Partial-strobe collision on addr 6: only lanes 0 and 1 forward in write-first.
        op(1'b1, 4'h3, 4'h6, 32'h1122_3344, 1'b1, 4'h6, 32'h0, 32'h0000_3344);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h6, 32'h0000_3344, 32'h0000_3344);

        // Read and write to different addresses on one edge do not interact.
        op(1'b1, 4'hF, 4'h7, 32'hCAFE_F00D, 1'b1, 4'h3, 32'hAA22_CC44, 32'hAA22_CC44);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h7, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Fill addrs 0..2, then four back-to-back reads over 0..3.
        op(1'b1, 4'hF, 4'h0, 32'h1000_0001, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b1, 4'hF, 4'h1, 32'h2000_0002, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b1, 4'hF, 4'h2, 32'h3000_0003, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h1000_0001, 32'h1000_0001);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h1, 32'h2000_0002, 32'h2000_0002);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h2, 32'h3000_0003, 32'h3000_0003);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3, 32'hAA22_CC44, 32'hAA22_CC44);
        idle(4);

        // DOUT holds the last read word while idle.
        check("hold_dout_a", dout_a, 32'hAA22_CC44);
        check("hold_dout_b", dout_b, 32'hAA22_CC44);

        // Reset pulsed at clear count 7: clear restarts and lasts 16 cycles from release.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (7) @(negedge CLK);
        check("mid_clear_busy", {30'b0, busy_a, busy_b}, 32'h3);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_busy", {30'b0, busy_a, busy_b}, 32'h3);
        check("mid_rst_dout", dout_a | dout_b, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        count_busy("busy_len_restart");

        // The restarted clear reached every address.
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3, 32'h0, 32'h0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h7, 32'h0, 32'h0);
        op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h0, 32'h0);
        idle(4);

        check("qa_drained", qa.size(), 32'h0);
        check("qb_drained", qb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
